// File: rtl/cpu_pkg.sv
// Shared encodings for the memory request arbiter: owner tags stored in the
// response-ordering FIFO, arbiter state encoding and access-size codes.
package cpu_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_st_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bus.
//   master: drives req, wr, size, wstrb, addr, wdata; receives addr_ok, data_ok, rdata
//   slave : the opposite direction
// Used for the fetch port, the data port and the memory-bridge port.
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/owner_fifo.sv
// Small in-order FIFO recording which requester owns each accepted request.
//   clk, resetn : clock, async active-low reset (clears pointers and count)
//   push, din   : write din at the tail
//   pop         : drop the head entry
//   head        : current head entry (valid when !empty)
//   count       : occupancy, full/empty flags
// Push and pop may occur in the same cycle; the caller never pops when empty
// and never pushes when full without also popping.
module owner_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 1,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory-bridge port between instruction fetch and data access.
//   clk, resetn : clock, async active-low reset
//   inst        : fetch requester (slave side); only req/addr are used
//   data        : data requester (slave side), fixed priority over fetch
//   mem         : bridge port (master side)
// A grant is held until the bridge accepts the address; owners of accepted
// requests are queued in order so responses route back to the right port.
module mem_req_arbiter
    import cpu_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                resetn,
    mem_req_arbiter_if.slave    inst,
    mem_req_arbiter_if.slave    data,
    mem_req_arbiter_if.master   mem
);

    localparam int CW = $clog2(OUTSTANDING) + 1;

    arb_st_e       st, st_nxt;
    logic          sel;
    logic          sel_req;
    logic          accept;
    logic          resp_vld;
    logic          head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // Fetch never writes; these fields exist on the shared bus type only.
    logic unused_inst;
    assign unused_inst = ^{inst.wr, inst.size, inst.wstrb, inst.wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) st <= ARB_IDLE;
        else         st <= st_nxt;
    end

    always_comb begin
        st_nxt    = st;
        sel       = OWNER_INST;
        mem.wr    = 1'b0;
        mem.size  = 2'd0;
        mem.wstrb = 4'd0;
        mem.addr  = 32'd0;
        mem.wdata = 32'd0;

        // Held grants ignore a newly arriving data request.
        case (st)
            ARB_HOLD_I: sel = OWNER_INST;
            ARB_HOLD_D: sel = OWNER_DATA;
            default:    sel = data.req ? OWNER_DATA : OWNER_INST;
        endcase

        sel_req = (sel == OWNER_DATA) ? data.req : inst.req;
        mem.req = sel_req & ~full;

        // Fields are zero unless a request is actually presented.
        if (mem.req) begin
            if (sel == OWNER_DATA) begin
                mem.wr    = data.wr;
                mem.size  = data.size;
                mem.wstrb = data.wstrb;
                mem.addr  = data.addr;
                mem.wdata = data.wdata;
            end else begin
                mem.size  = SZ_W;
                mem.addr  = inst.addr;
            end
        end

        accept       = mem.req & mem.addr_ok;
        inst.addr_ok = accept & (sel == OWNER_INST);
        data.addr_ok = accept & (sel == OWNER_DATA);

        if (!full) begin
            case (st)
                ARB_IDLE: begin
                    if (mem.req && !mem.addr_ok)
                        st_nxt = (sel == OWNER_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
                end
                ARB_HOLD_I, ARB_HOLD_D: begin
                    if (accept) st_nxt = ARB_IDLE;
                end
                default: st_nxt = ARB_IDLE;
            endcase
        end
    end

    // A response with no recorded owner is dropped.
    assign resp_vld     = mem.data_ok & ~empty;
    assign inst.data_ok = resp_vld & (head == OWNER_INST);
    assign data.data_ok = resp_vld & (head == OWNER_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (resp_vld),
        .din    (sel),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

endmodule
